rh_xfer_seq: RTL and testbench

//  RH11 Massbus<->Unibus DMA transfer sequencer. Runs the word-by-word data transfer for

---
 rtl/rh_xfer_seq_pkg.sv | 32 +++
 rtl/rh_xfer_seq_if.sv | 26 ++
 rtl/rh_xfer_seq_timer.sv | 31 +++
 rtl/rh_xfer_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_rh_xfer_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rh_xfer_seq_pkg.sv
// Shared codes and state encoding for the RH11 DMA transfer sequencer.
// The RH_WCHK_EN macro adds the write-check compare state.
package rh_xfer_seq_pkg;

    localparam int unsigned DATA_W = 36;
    localparam int unsigned WC_W   = 16;
    localparam int unsigned BA_W   = 18;

    localparam logic [1:0] FUN_NONE  = 2'b00;
    localparam logic [1:0] FUN_WRITE = 2'b01;
    localparam logic [1:0] FUN_READ  = 2'b10;
    localparam logic [1:0] FUN_WCHK  = 2'b11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MRD   = 3'd1;
    localparam logic [2:0] ST_DWAIT = 3'd2;
    localparam logic [2:0] ST_MWR   = 3'd3;
    localparam logic [2:0] ST_CMP   = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_MRD   = ST_MRD,
        S_DWAIT = ST_DWAIT,
        S_MWR   = ST_MWR,
`ifdef RH_WCHK_EN
        S_CMP   = ST_CMP,
`endif
        S_DONE  = ST_DONE
    } state_t;

endpackage

// File: rtl/rh_xfer_seq_if.sv
// DMA port and drive data port of the RH11 transfer sequencer.
interface rh_xfer_seq_if;
    import rh_xfer_seq_pkg::*;

    logic              dmaREQ;
    logic              dmaWR;
    logic [BA_W-1:0]   dmaADDR;
    logic [DATA_W-1:0] dmaDATAO;
    logic [DATA_W-1:0] dmaDATAI;
    logic              dmaACK;
    logic              drvREQ;
    logic [DATA_W-1:0] drvDATAI;
    logic [DATA_W-1:0] drvDATAO;
    logic              drvACK;

    modport master (
        output dmaREQ, dmaWR, dmaADDR, dmaDATAO, drvDATAO, drvACK,
        input  dmaDATAI, dmaACK, drvREQ, drvDATAI
    );

    modport slave (
        input  dmaREQ, dmaWR, dmaADDR, dmaDATAO, drvDATAO, drvACK,
        output dmaDATAI, dmaACK, drvREQ, drvDATAI
    );

endinterface

// File: rtl/rh_xfer_seq_timer.sv
// Non-existent-memory watchdog: counts while a DMA request is pending and
// pulses expire in the cycle the request reaches TIMEOUT cycles of age.
module rh_xfer_seq_timer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic ack,
    output logic expire
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    logic [CNT_W-1:0] cnt;

    // expire is registered one cycle early so it lines up with request age TIMEOUT-1
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (start && !ack) begin
            cnt    <= cnt + CNT_W'(1);
            expire <= (cnt == CNT_W'(TIMEOUT - 2));
        end else begin
            cnt    <= '0;
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/rh_xfer_seq.sv
// RH11 Massbus<->Unibus word transfer sequencer (read, write, write-check).
// Define RH_WCHK_EN to enable the write-check compare; otherwise function 11 discards drive data.
module rh_xfer_seq
    import rh_xfer_seq_pkg::*;
#(
    parameter int unsigned NEM_TIMEOUT = 64,
    parameter int unsigned BA_INC      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              devRESET,
    input  logic              rhCLR,
    input  logic              xferGO,
    input  logic [1:0]        xferFUN,
    input  logic              rhBAI,
    input  logic              wcLOAD,
    input  logic              baLOAD,
    input  logic [DATA_W-1:0] rhDATAI,
    rh_xfer_seq_if.master     xfer,
    output logic [WC_W-1:0]   rhWC,
    output logic [BA_W-1:0]   rhBA,
    output logic              bufIR,
    output logic              bufOR,
    output logic              setNEM,
    output logic              setDLT,
    output logic              setWCE,
    output logic              xferBUSY,
    output logic              xferDONE
);

`ifdef RH_WCHK_EN
    localparam bit WCHK = 1'b1;
`else
    localparam bit WCHK = 1'b0;
`endif

    state_t            state;
    logic [1:0]        fun;
    logic [DATA_W-1:0] ir_buf;
    logic [DATA_W-1:0] or_buf;
    logic              dma_req;
    logic              dma_wr;
    logic              expire;
    logic              clr;
    logic              fetch_c;
    logic              fetch_go_c;
    logic              dlt_c;
    logic              drv_take_c;
    logic              complete_c;
    logic [WC_W-1:0]   wc_inc;
    logic [BA_W-1:0]   ba_next;
    logic              unused_hi;

    assign clr        = rst | devRESET | rhCLR;
    assign unused_hi  = ^rhDATAI[DATA_W-1:BA_W];
    assign fetch_c    = (fun == FUN_WRITE) || (WCHK && (fun == FUN_WCHK));
    assign fetch_go_c = (xferFUN == FUN_WRITE) || (WCHK && (xferFUN == FUN_WCHK));
    assign wc_inc     = rhWC + WC_W'(1);
    assign ba_next    = rhBAI ? rhBA : rhBA + BA_W'(BA_INC);

    // Drive asks before its buffer is ready: nothing to give, or previous word not yet stored
    assign dlt_c      = xferBUSY && xfer.drvREQ && (fetch_c ? !bufOR : bufIR);
    // Combinational so the drive sees its ack in the same cycle as its request
    assign drv_take_c = (state == S_DWAIT) && xfer.drvREQ && !dlt_c;

    always_comb begin
        complete_c = 1'b0;
        case (state)
            S_DWAIT: complete_c = drv_take_c &&
                                  ((fun == FUN_WRITE) || (!WCHK && (fun == FUN_WCHK)));
            S_MWR:   complete_c = xfer.dmaACK;
`ifdef RH_WCHK_EN
            S_CMP:   complete_c = 1'b1;
`endif
            default: complete_c = 1'b0;
        endcase
    end

    assign xfer.dmaREQ   = dma_req;
    assign xfer.dmaWR    = dma_wr;
    assign xfer.dmaADDR  = rhBA;
    assign xfer.dmaDATAO = ir_buf;
    assign xfer.drvDATAO = or_buf;
    assign xfer.drvACK   = drv_take_c;

    rh_xfer_seq_timer #(.TIMEOUT(NEM_TIMEOUT)) u_timer (
        .clk    (clk),
        .rst    (clr),
        .start  (dma_req),
        .ack    (xfer.dmaACK),
        .expire (expire)
    );

`ifdef RH_WCHK_EN
    logic wce_q;
    assign setWCE = wce_q;
`else
    assign setWCE = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= S_IDLE;
            fun      <= FUN_NONE;
            ir_buf   <= '0;
            or_buf   <= '0;
            dma_req  <= 1'b0;
            dma_wr   <= 1'b0;
            rhWC     <= '0;
            rhBA     <= '0;
            bufIR    <= 1'b0;
            bufOR    <= 1'b0;
            setNEM   <= 1'b0;
            setDLT   <= 1'b0;
            xferBUSY <= 1'b0;
            xferDONE <= 1'b0;
`ifdef RH_WCHK_EN
            wce_q    <= 1'b0;
`endif
        end else begin
            setNEM   <= 1'b0;
            setDLT   <= 1'b0;
            xferDONE <= 1'b0;
`ifdef RH_WCHK_EN
            wce_q    <= 1'b0;
`endif
            if (dlt_c) begin
                setDLT   <= 1'b1;
                dma_req  <= 1'b0;
                dma_wr   <= 1'b0;
                xferBUSY <= 1'b0;
                xferDONE <= 1'b1;
                state    <= S_DONE;
            end else if (complete_c) begin
                // Word finished: advance counters, then next word or terminate
                rhWC    <= wc_inc;
                rhBA    <= ba_next;
                dma_req <= 1'b0;
                dma_wr  <= 1'b0;
                if (state == S_MWR)   bufIR <= 1'b0;
                if (state == S_DWAIT) bufOR <= 1'b0;
`ifdef RH_WCHK_EN
                if (state == S_CMP) begin
                    if (ir_buf != or_buf) begin
                        wce_q <= 1'b1;
                    end else begin
                        bufIR <= 1'b0;
                        bufOR <= 1'b0;
                    end
                end
                if ((wc_inc == '0) || ((state == S_CMP) && (ir_buf != or_buf))) begin
`else
                if (wc_inc == '0) begin
`endif
                    xferBUSY <= 1'b0;
                    xferDONE <= 1'b1;
                    state    <= S_DONE;
                end else if (fetch_c) begin
                    dma_req <= 1'b1;
                    state   <= S_MRD;
                end else begin
                    state <= S_DWAIT;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (wcLOAD) rhWC <= rhDATAI[WC_W-1:0];
                        if (baLOAD) rhBA <= rhDATAI[BA_W-1:0];
                        if (xferGO && (xferFUN != FUN_NONE)) begin
                            fun      <= xferFUN;
                            xferBUSY <= 1'b1;
                            if (fetch_go_c) begin
                                dma_req <= 1'b1;
                                dma_wr  <= 1'b0;
                                state   <= S_MRD;
                            end else begin
                                state <= S_DWAIT;
                            end
                        end
                    end
                    S_MRD: begin
                        if (xfer.dmaACK) begin
                            or_buf  <= xfer.dmaDATAI;
                            bufOR   <= 1'b1;
                            dma_req <= 1'b0;
                            state   <= S_DWAIT;
                        end else if (expire) begin
                            setNEM   <= 1'b1;
                            dma_req  <= 1'b0;
                            xferBUSY <= 1'b0;
                            xferDONE <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                    S_DWAIT: begin
                        if (drv_take_c && (fun == FUN_READ)) begin
                            ir_buf  <= xfer.drvDATAI;
                            bufIR   <= 1'b1;
                            dma_req <= 1'b1;
                            dma_wr  <= 1'b1;
                            state   <= S_MWR;
                        end
`ifdef RH_WCHK_EN
                        else if (drv_take_c && (fun == FUN_WCHK)) begin
                            ir_buf <= xfer.drvDATAI;
                            bufIR  <= 1'b1;
                            state  <= S_CMP;
                        end
`endif
                    end
                    S_MWR: begin
                        if (expire) begin
                            setNEM   <= 1'b1;
                            dma_req  <= 1'b0;
                            dma_wr   <= 1'b0;
                            xferBUSY <= 1'b0;
                            xferDONE <= 1'b1;
                            state    <= S_DONE;
                        end
                    end
                    S_DONE:  state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rh_xfer_seq.sv
// Directed bench for rh_xfer_seq: a cycle table for a 3-word read plus
// hand-written sequences for BAI, NEM timeout, data late, write-check and clear.
module tb_rh_xfer_seq;

    localparam int unsigned NEM_T = 64;

    logic        clk = 1'b0;
    logic        rst, devRESET, rhCLR, xferGO, rhBAI, wcLOAD, baLOAD;
    logic [1:0]  xferFUN;
    logic [35:0] rhDATAI;
    logic [15:0] rhWC;
    logic [17:0] rhBA;
    logic        bufIR, bufOR, setNEM, setDLT, setWCE, xferBUSY, xferDONE;

    int n_cmp = 0;
    int n_bad = 0;
    int found;
    logic seen;

    rh_xfer_seq_if bus ();

    rh_xfer_seq #(.NEM_TIMEOUT(NEM_T), .BA_INC(4)) dut (
        .clk(clk), .rst(rst), .devRESET(devRESET), .rhCLR(rhCLR),
        .xferGO(xferGO), .xferFUN(xferFUN), .rhBAI(rhBAI),
        .wcLOAD(wcLOAD), .baLOAD(baLOAD), .rhDATAI(rhDATAI),
        .xfer(bus),
        .rhWC(rhWC), .rhBA(rhBA), .bufIR(bufIR), .bufOR(bufOR),
        .setNEM(setNEM), .setDLT(setDLT), .setWCE(setWCE),
        .xferBUSY(xferBUSY), .xferDONE(xferDONE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        go;
        logic [1:0]  fun;
        logic        wcl;
        logic        bal;
        logic [35:0] d;
        logic        dack;
        logic        dreq;
        logic [35:0] rdat;
        logic [17:0] e_addr;
        logic [15:0] e_wc;
        logic [7:0]  e_flags;   // {dmaREQ,dmaWR,drvACK,bufIR,bufOR,BUSY,DONE,any error}
        logic [35:0] e_dout;
    } vec_t;

    vec_t vt[17];

    function automatic vec_t mk(logic go, logic [1:0] fun, logic wcl, logic bal,
                                logic [35:0] d, logic dack, logic dreq, logic [35:0] rdat,
                                logic [17:0] a, logic [15:0] wc, logic [7:0] f, logic [35:0] o);
        vec_t v;
        v.go = go; v.fun = fun; v.wcl = wcl; v.bal = bal; v.d = d; v.dack = dack;
        v.dreq = dreq; v.rdat = rdat; v.e_addr = a; v.e_wc = wc; v.e_flags = f; v.e_dout = o;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        rst = 1'b0; devRESET = 1'b0; rhCLR = 1'b0;
        xferGO = 1'b0; xferFUN = 2'b00; wcLOAD = 1'b0; baLOAD = 1'b0; rhDATAI = '0;
        bus.dmaACK = 1'b0; bus.dmaDATAI = '0; bus.drvREQ = 1'b0; bus.drvDATAI = '0;
    endtask

    task automatic nxt();
        @(negedge clk);
        idle_in();
    endtask

    task automatic do_clear();
        nxt(); rst = 1'b1;
        nxt();
    endtask

    task automatic setup(input logic [17:0] ba, input logic [15:0] wc, input logic [1:0] f);
        nxt(); baLOAD = 1'b1; rhDATAI = 36'(ba);
        nxt(); wcLOAD = 1'b1; rhDATAI = 36'(wc);
        nxt(); xferGO = 1'b1; xferFUN = f;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] flags;
        idle_in();
        rhBAI = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 3-word read from 0o1000, one table row per cycle
        vt[0]  = mk(0, 2'b00, 0, 1, 36'o1000, 0, 0, 36'h0,  18'o0,    16'h0000, 8'b0000_0000, 36'h0);
        vt[1]  = mk(0, 2'b00, 1, 0, 36'hFFFD, 0, 0, 36'h0,  18'o1000, 16'h0000, 8'b0000_0000, 36'h0);
        vt[2]  = mk(1, 2'b10, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1000, 16'hFFFD, 8'b0000_0000, 36'h0);
        vt[3]  = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1000, 16'hFFFD, 8'b0000_0100, 36'h0);
        vt[4]  = mk(0, 2'b00, 0, 0, 36'h0,    0, 1, 36'hA1, 18'o1000, 16'hFFFD, 8'b0010_0100, 36'h0);
        vt[5]  = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1000, 16'hFFFD, 8'b1101_0100, 36'hA1);
        vt[6]  = mk(0, 2'b00, 0, 0, 36'h0,    1, 0, 36'h0,  18'o1000, 16'hFFFD, 8'b1101_0100, 36'hA1);
        vt[7]  = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1004, 16'hFFFE, 8'b0000_0100, 36'hA1);
        vt[8]  = mk(0, 2'b00, 0, 0, 36'h0,    0, 1, 36'hA2, 18'o1004, 16'hFFFE, 8'b0010_0100, 36'hA1);
        vt[9]  = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1004, 16'hFFFE, 8'b1101_0100, 36'hA2);
        vt[10] = mk(0, 2'b00, 0, 0, 36'h0,    1, 0, 36'h0,  18'o1004, 16'hFFFE, 8'b1101_0100, 36'hA2);
        vt[11] = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1010, 16'hFFFF, 8'b0000_0100, 36'hA2);
        vt[12] = mk(0, 2'b00, 0, 0, 36'h0,    0, 1, 36'hA3, 18'o1010, 16'hFFFF, 8'b0010_0100, 36'hA2);
        vt[13] = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1010, 16'hFFFF, 8'b1101_0100, 36'hA3);
        vt[14] = mk(0, 2'b00, 0, 0, 36'h0,    1, 0, 36'h0,  18'o1010, 16'hFFFF, 8'b1101_0100, 36'hA3);
        vt[15] = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1014, 16'h0000, 8'b0000_0010, 36'hA3);
        vt[16] = mk(0, 2'b00, 0, 0, 36'h0,    0, 0, 36'h0,  18'o1014, 16'h0000, 8'b0000_0000, 36'hA3);

        for (int i = 0; i < 17; i++) begin
            nxt();
            xferGO = vt[i].go; xferFUN = vt[i].fun; wcLOAD = vt[i].wcl; baLOAD = vt[i].bal;
            rhDATAI = vt[i].d; bus.dmaACK = vt[i].dack; bus.drvREQ = vt[i].dreq;
            bus.drvDATAI = vt[i].rdat;
            #1;
            flags = {bus.dmaREQ, bus.dmaWR, bus.drvACK, bufIR, bufOR, xferBUSY, xferDONE,
                     setNEM | setDLT | setWCE};
            chk($sformatf("t1 row%0d flags", i), 64'(flags), 64'(vt[i].e_flags));
            chk($sformatf("t1 row%0d WC", i), 64'(rhWC), 64'(vt[i].e_wc));
            chk($sformatf("t1 row%0d BA", i), 64'(rhBA), 64'(vt[i].e_addr));
            chk($sformatf("t1 row%0d dmaADDR", i), 64'(bus.dmaADDR), 64'(vt[i].e_addr));
            chk($sformatf("t1 row%0d dmaDATAO", i), 64'(bus.dmaDATAO), 64'(vt[i].e_dout));
        end

        // Write with BAI: both fetches at the same address, drive gets memory data
        do_clear();
        rhBAI = 1'b1;
        setup(18'h40, 16'hFFFE, 2'b01);
        nxt(); bus.dmaACK = 1'b1; bus.dmaDATAI = 36'h123456789; #1;
        chk("t2 req1", 64'(bus.dmaREQ), 64'd1);
        chk("t2 wr1", 64'(bus.dmaWR), 64'd0);
        chk("t2 addr1", 64'(bus.dmaADDR), 64'h40);
        nxt(); wcLOAD = 1'b1; rhDATAI = 36'h1234; xferGO = 1'b1; xferFUN = 2'b10; #1;
        chk("t2 bufOR1", 64'(bufOR), 64'd1);
        chk("t2 req drop", 64'(bus.dmaREQ), 64'd0);
        nxt(); bus.drvREQ = 1'b1; #1;
        chk("t2 drvACK1", 64'(bus.drvACK), 64'd1);
        chk("t2 drvDATAO1", 64'(bus.drvDATAO), 64'h123456789);
        chk("t2 wc load ignored", 64'(rhWC), 64'hFFFE);
        nxt(); #1;
        chk("t2 bufOR empty", 64'(bufOR), 64'd0);
        chk("t2 req2", 64'(bus.dmaREQ), 64'd1);
        chk("t2 addr2", 64'(bus.dmaADDR), 64'h40);
        chk("t2 wc2", 64'(rhWC), 64'hFFFF);
        nxt(); bus.dmaACK = 1'b1; bus.dmaDATAI = 36'hFEDCBA987;
        nxt(); bus.drvREQ = 1'b1; #1;
        chk("t2 drvACK2", 64'(bus.drvACK), 64'd1);
        chk("t2 drvDATAO2", 64'(bus.drvDATAO), 64'hFEDCBA987);
        nxt(); #1;
        chk("t2 done", 64'(xferDONE), 64'd1);
        chk("t2 wc end", 64'(rhWC), 64'h0);
        chk("t2 ba end", 64'(rhBA), 64'h40);
        chk("t2 busy end", 64'(xferBUSY), 64'd0);
        rhBAI = 1'b0;

        // No ACK: NEM exactly NEM_T cycles after dmaREQ rises
        do_clear();
        setup(18'h0, 16'hFFFF, 2'b01);
        nxt(); #1;
        chk("t3 req rise", 64'(bus.dmaREQ), 64'd1);
        found = -1;
        seen = 1'b0;
        for (int c = 1; c <= int'(NEM_T) + 8; c++) begin
            nxt(); #1;
            if (setNEM && found < 0) begin
                found = c;
                seen  = xferDONE && !bus.dmaREQ;
            end
        end
        chk("t3 nem cycle", 64'(found), 64'(NEM_T));
        chk("t3 done and req drop", 64'(seen), 64'd1);

        // ACK on the expiry cycle wins over the timeout
        do_clear();
        setup(18'h0, 16'hFFFF, 2'b01);
        nxt(); #1;
        chk("t3b req rise", 64'(bus.dmaREQ), 64'd1);
        for (int c = 1; c < int'(NEM_T) - 1; c++) nxt();
        nxt(); bus.dmaACK = 1'b1; bus.dmaDATAI = 36'h55; #1;
        chk("t3b req at expiry", 64'(bus.dmaREQ), 64'd1);
        seen = 1'b0;
        nxt(); #1;
        chk("t3b bufOR", 64'(bufOR), 64'd1);
        for (int c = 0; c < 4; c++) begin
            seen = seen | setNEM;
            nxt(); #1;
        end
        chk("t3b no nem", 64'(seen), 64'd0);
        nxt(); bus.drvREQ = 1'b1;
        nxt(); #1;
        chk("t3b done", 64'(xferDONE), 64'd1);

        // Read: second drvREQ before the memory write completes -> data late
        do_clear();
        setup(18'h0, 16'hFFFD, 2'b10);
        nxt(); bus.drvREQ = 1'b1; bus.drvDATAI = 36'h11; #1;
        chk("t4 drvACK1", 64'(bus.drvACK), 64'd1);
        nxt(); #1;
        chk("t4 bufIR", 64'(bufIR), 64'd1);
        nxt(); bus.drvREQ = 1'b1; bus.drvDATAI = 36'h22; #1;
        chk("t4 no drvACK", 64'(bus.drvACK), 64'd0);
        nxt(); #1;
        chk("t4 setDLT", 64'(setDLT), 64'd1);
        chk("t4 done", 64'(xferDONE), 64'd1);
        chk("t4 bufIR kept", 64'(bufIR), 64'd1);
        chk("t4 req drop", 64'(bus.dmaREQ), 64'd0);
        chk("t4 wc", 64'(rhWC), 64'hFFFD);

`ifdef RH_WCHK_EN
        // Write-check: word 1 matches, word 2 mismatches
        do_clear();
        setup(18'h0, 16'hFFFC, 2'b11);
        nxt(); bus.dmaACK = 1'b1; bus.dmaDATAI = 36'h777; #1;
        chk("t5 req1", 64'(bus.dmaREQ), 64'd1);
        nxt(); bus.drvREQ = 1'b1; bus.drvDATAI = 36'h777; #1;
        chk("t5 drvACK1", 64'(bus.drvACK), 64'd1);
        nxt(); #1;
        chk("t5 bufIR cmp", 64'(bufIR), 64'd1);
        nxt(); #1;
        chk("t5 wc1", 64'(rhWC), 64'hFFFD);
        chk("t5 buffers clear", 64'({bufIR, bufOR}), 64'd0);
        chk("t5 req2", 64'(bus.dmaREQ), 64'd1);
        chk("t5 addr2", 64'(bus.dmaADDR), 64'h4);
        nxt(); bus.dmaACK = 1'b1; bus.dmaDATAI = 36'h888;
        nxt(); bus.drvREQ = 1'b1; bus.drvDATAI = 36'h889;
        nxt(); #1;
        chk("t5 no wce yet", 64'(setWCE), 64'd0);
        nxt(); #1;
        chk("t5 setWCE", 64'(setWCE), 64'd1);
        chk("t5 done", 64'(xferDONE), 64'd1);
        chk("t5 wc end", 64'(rhWC), 64'hFFFE);
`else
        // Function 11 without write-check: read with no memory traffic
        do_clear();
        setup(18'h0, 16'hFFFE, 2'b11);
        nxt(); bus.drvREQ = 1'b1; bus.drvDATAI = 36'h99; #1;
        chk("t5 no req", 64'(bus.dmaREQ), 64'd0);
        chk("t5 drvACK1", 64'(bus.drvACK), 64'd1);
        nxt(); #1;
        chk("t5 wc1", 64'(rhWC), 64'hFFFF);
        chk("t5 no req2", 64'(bus.dmaREQ), 64'd0);
        chk("t5 bufIR", 64'(bufIR), 64'd0);
        nxt(); bus.drvREQ = 1'b1;
        nxt(); #1;
        chk("t5 done", 64'(xferDONE), 64'd1);
        chk("t5 wc end", 64'(rhWC), 64'h0);
        chk("t5 no wce", 64'(setWCE), 64'd0);
`endif

        // Controller clear during MRD aborts silently
        do_clear();
        setup(18'h100, 16'hFFF0, 2'b01);
        nxt(); rhCLR = 1'b1; #1;
        chk("t6 req before clr", 64'(bus.dmaREQ), 64'd1);
        nxt(); #1;
        chk("t6 req after clr", 64'(bus.dmaREQ), 64'd0);
        chk("t6 busy", 64'(xferBUSY), 64'd0);
        chk("t6 wc", 64'(rhWC), 64'h0);
        chk("t6 ba", 64'(rhBA), 64'h0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            seen = seen | xferDONE | setNEM;
            nxt(); #1;
        end
        chk("t6 no done", 64'(seen), 64'd0);

        // devRESET clears loaded registers
        nxt(); wcLOAD = 1'b1; rhDATAI = 36'h00ABC;
        nxt(); #1;
        chk("t7 wc loaded", 64'(rhWC), 64'hABC);
        nxt(); devRESET = 1'b1;
        nxt(); #1;
        chk("t7 wc reset", 64'(rhWC), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
